// File: rtl/mem_arbiter.sv
// mem_arbiter: grants the byte-serial memory controller to fetch or LSB, LSB-first with fetch anti-starvation
module mem_arbiter #(
  parameter int          STARVE_LIMIT = 4,
  parameter logic [31:0] IO_BASE      = 32'h00030000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic        io_buffer_full,
  input  logic        if_en,
  input  logic [31:0] if_addr,
  output logic        if_rdy,
  output logic [31:0] if_data,
  input  logic        lsb_en,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [3:0]  lsb_type,
  input  logic [31:0] lsb_wdata,
  output logic        lsb_rdy,
  output logic [31:0] lsb_rdata,
  output logic        mc_en,
  output logic        mc_wr,
  output logic [31:0] mc_addr,
  output logic [3:0]  mc_type,
  output logic [31:0] mc_wdata,
  input  logic        mc_rdy,
  input  logic [31:0] mc_rdata
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_d;
  logic [CW-1:0] starve_cnt, cnt_d;
  logic drop, drop_d, own_lsb, own_d;
  logic en_d, wr_d, if_rdy_d, lsb_rdy_d;
  logic [31:0] addr_d, wdata_d, if_data_d, lsb_rdata_d;
  logic [3:0] type_d;
  logic lsb_ok, pick_lsb;
  // IO stores wait while the IO buffer is full; loads are always allowed
  assign lsb_ok   = lsb_en && (!lsb_wr || !(lsb_addr >= IO_BASE && io_buffer_full));
  assign pick_lsb = lsb_ok && (!if_en || starve_cnt < LIM);
  // next-state and registered-output logic; grants only from IDLE, so RESP never regrants a held-over request
  always_comb begin
    state_d = state;
    cnt_d = starve_cnt;
    drop_d = drop;
    own_d = own_lsb;
    en_d = mc_en;
    wr_d = mc_wr;
    addr_d = mc_addr;
    type_d = mc_type;
    wdata_d = mc_wdata;
    if_rdy_d = 1'b0;
    lsb_rdy_d = 1'b0;
    if_data_d = if_data;
    lsb_rdata_d = lsb_rdata;
    case (state)
      IDLE: if (!flush && (lsb_ok || if_en)) begin
        own_d = pick_lsb;
        en_d = 1'b1;
        wr_d = pick_lsb && lsb_wr;
        addr_d = pick_lsb ? lsb_addr : if_addr;
        type_d = pick_lsb ? lsb_type : 4'b0010;
        wdata_d = pick_lsb ? lsb_wdata : 32'd0;
        cnt_d = (pick_lsb && if_en) ? ((starve_cnt == LIM) ? LIM : starve_cnt + 1'b1) : '0;
        state_d = BUSY;
      end
      BUSY: begin
        drop_d = drop | (flush & ~mc_wr);
        if (mc_rdy) begin
          en_d = 1'b0;
          state_d = RESP;
          if_rdy_d = !drop_d && !own_lsb;
          lsb_rdy_d = !drop_d && own_lsb;
          if_data_d = (!drop_d && !own_lsb) ? mc_rdata : if_data;
          lsb_rdata_d = (!drop_d && own_lsb) ? mc_rdata : lsb_rdata;
        end
      end
      default: begin
        drop_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  // state register; everything freezes while rdy_in is low
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
      starve_cnt <= '0;
      drop <= 1'b0;
      own_lsb <= 1'b0;
      mc_en <= 1'b0;
      mc_wr <= 1'b0;
      mc_addr <= '0;
      mc_type <= '0;
      mc_wdata <= '0;
      if_rdy <= 1'b0;
      if_data <= '0;
      lsb_rdy <= 1'b0;
      lsb_rdata <= '0;
    end else if (rdy_in) begin
      state <= state_d;
      starve_cnt <= cnt_d;
      drop <= drop_d;
      own_lsb <= own_d;
      mc_en <= en_d;
      mc_wr <= wr_d;
      mc_addr <= addr_d;
      mc_type <= type_d;
      mc_wdata <= wdata_d;
      if_rdy <= if_rdy_d;
      if_data <= if_data_d;
      lsb_rdy <= lsb_rdy_d;
      lsb_rdata <= lsb_rdata_d;
    end
  end
endmodule
